// File: rtl/exe_seq_pkg.sv
// Shared types for the sequential execution unit.
//   oper_e      : opcode encoding seen on i_oper[2:0]
//   status_e    : result status reported on o_status
//   state_e     : control FSM states of exe_unit_seq
//   status_prio : folds the raw error/overflow/zero flags into one status code
package exe_seq_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MAX = 3'd2,
    NEG = 3'd3,
    MUL = 3'd4,
    DIV = 3'd5
  } oper_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_OVF  = 2'b01,
    ST_ZERO = 2'b10,
    ST_ERR  = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // ERR outranks OVF, which outranks ZERO; anything else is OK.
  function automatic status_e status_prio(input logic err, input logic ovf, input logic zero);
    if (err)  return ST_ERR;
    if (ovf)  return ST_OVF;
    if (zero) return ST_ZERO;
    return ST_OK;
  endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned multiplier / restoring divider on operand magnitudes.
// Both datapaths step together every cycle; the parent picks whichever result
// it needs. A start pulse loads the operands and a counter of M; each following
// cycle performs one iteration. o_last is high during the final iteration, and
// o_prod / o_quot carry the values that iteration produces, so the parent can
// register the finished result on that same edge.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_start            load i_a_mag / i_b_mag and begin M iterations
//   i_a_mag, i_b_mag   unsigned magnitudes (multiplicand/dividend, multiplier/divisor)
//   o_last             final iteration in progress
//   o_prod             2M-bit product after the current iteration
//   o_quot             M-bit quotient after the current iteration
module seq_muldiv_core #(
  parameter int M = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [M-1:0]   i_a_mag,
  input  logic [M-1:0]   i_b_mag,
  output logic           o_last,
  output logic [2*M-1:0] o_prod,
  output logic [M-1:0]   o_quot
);

  localparam int CW = $clog2(M + 1);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*M-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [M-1:0]   mplier_q, mplier_d;
  logic [M-1:0]   quot_q, quot_d, rem_q, rem_d, dvsr_q, dvsr_d;

  logic [2*M-1:0] acc_step;
  logic [M-1:0]   quot_step, rem_step;
  logic [M:0]     rem_shift;

  always_comb begin
    // Shift-add: add the shifted multiplicand whenever the multiplier LSB is set.
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Restoring division: the quotient register doubles as the dividend shifter,
    // so its MSB feeds the partial remainder as quotient bits enter at the LSB.
    rem_shift = {rem_q, quot_q[M-1]};
    if (rem_shift >= {1'b0, dvsr_q}) begin
      rem_step  = M'(rem_shift - {1'b0, dvsr_q});
      quot_step = {quot_q[M-2:0], 1'b1};
    end else begin
      rem_step  = rem_shift[M-1:0];
      quot_step = {quot_q[M-2:0], 1'b0};
    end

    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;

    if (i_start) begin
      cnt_d    = CW'(M);
      acc_d    = '0;
      mcand_d  = {{M{1'b0}}, i_a_mag};
      mplier_d = i_b_mag;
      quot_d   = i_a_mag;
      rem_d    = '0;
      dvsr_d   = i_b_mag;
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - CW'(1);
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      quot_d   = quot_step;
      rem_d    = rem_step;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
    end
  end

  assign o_last = (cnt_q == CW'(1));
  assign o_prod = acc_step;
  assign o_quot = quot_step;

endmodule

// File: rtl/exe_unit_seq.sv
// Handshaked signed execution unit, one operation in flight at a time.
// ADD/SUB/MAX/NEG and illegal opcodes complete on the accept edge; MUL/DIV run
// M iterations in seq_muldiv_core and get their sign and status fixed up here.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_valid / o_ready   request handshake (o_ready only in IDLE)
//   i_oper              opcode, i_argA / i_argB signed operands
//   o_valid / i_ready   result handshake (result held until i_ready)
//   o_result, o_status  signed result and 2-bit status
module exe_unit_seq
  import exe_seq_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_oper,
  input  logic [M-1:0] i_argA,
  input  logic [M-1:0] i_argB,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [M-1:0] o_result,
  output logic [1:0]   o_status
);

  localparam logic [M-1:0] MIN_NEG = {1'b1, {(M-1){1'b0}}};

  state_e       state_q, state_d;
  status_e      status_q, status_d;
  logic [M-1:0] result_q, result_d, a_q, a_d, b_q, b_d;
  logic         is_div_q, is_div_d;

  logic         op_legal, op_is_md;
  logic [M-1:0] a_mag, b_mag;
  logic         core_start, core_last;
  logic [2*M-1:0] core_prod;
  logic [M-1:0] core_quot;

  logic [M-1:0] sc_sum, sc_dif, sc_result;
  logic         sc_err, sc_ovf;
  status_e      sc_status;

  logic         md_neg, md_err, md_ovf;
  logic [2*M-1:0] md_prod;
  logic [M:0]   md_hi;
  logic [M-1:0] md_quot, md_result;
  status_e      md_status;

  // Opcode bits above [2:0] must be zero, and codes 6/7 are unused.
  always_comb begin
    op_legal = ((i_oper >> 3) == '0) && (i_oper[2:0] <= 3'(DIV));
    op_is_md = op_legal && ((i_oper[2:0] == MUL) || (i_oper[2:0] == DIV));
    a_mag    = i_argA[M-1] ? -i_argA : i_argA;
    b_mag    = i_argB[M-1] ? -i_argB : i_argB;
  end

  // Single-cycle operations, evaluated straight from the request inputs.
  always_comb begin
    sc_sum    = i_argA + i_argB;
    sc_dif    = i_argA - i_argB;
    sc_result = '0;
    sc_err    = 1'b0;
    sc_ovf    = 1'b0;
    if (!op_legal) begin
      sc_err = 1'b1;
    end else begin
      case (i_oper[2:0])
        ADD: begin
          sc_result = sc_sum;
          sc_ovf    = (i_argA[M-1] == i_argB[M-1]) && (sc_sum[M-1] != i_argA[M-1]);
        end
        SUB: begin
          sc_result = sc_dif;
          sc_ovf    = (i_argA[M-1] != i_argB[M-1]) && (sc_dif[M-1] != i_argA[M-1]);
        end
        MAX: sc_result = ($signed(i_argA) > $signed(i_argB)) ? i_argA : i_argB;
        NEG: begin
          sc_result = -i_argA;
          sc_ovf    = (i_argA == MIN_NEG);
        end
        default: sc_result = '0;
      endcase
    end
    sc_status = status_prio(sc_err, sc_ovf, sc_result == '0);
  end

  // Sign fix-up of the magnitude result. A product fits in M signed bits only
  // when its top M+1 bits are all copies of the result sign.
  always_comb begin
    md_neg  = a_q[M-1] ^ b_q[M-1];
    md_prod = md_neg ? -core_prod : core_prod;
    md_hi   = md_prod[2*M-1:M-1];
    md_quot = md_neg ? -core_quot : core_quot;
    md_err  = 1'b0;
    if (is_div_q) begin
      md_err    = (b_q == '0);
      md_ovf    = (a_q == MIN_NEG) && (b_q == '1);
      md_result = md_err ? '0 : md_quot;
    end else begin
      md_ovf    = (md_hi != '0) && (md_hi != '1);
      md_result = md_prod[M-1:0];
    end
    md_status = status_prio(md_err, md_ovf, md_result == '0);
  end

  // Control: latch the request in IDLE, wait for the core in CALC, hold the
  // result in DONE until the consumer takes it.
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    result_d   = result_q;
    a_d        = a_q;
    b_d        = b_q;
    is_div_d   = is_div_q;
    core_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d      = i_argA;
          b_d      = i_argB;
          is_div_d = (i_oper[2:0] == DIV);
          if (op_is_md) begin
            core_start = 1'b1;
            state_d    = CALC;
          end else begin
            result_d = sc_result;
            status_d = sc_status;
            state_d  = DONE;
          end
        end
      end
      CALC: begin
        if (core_last) begin
          result_d = md_result;
          status_d = md_status;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      status_q <= ST_OK;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
    end
  end

  seq_muldiv_core #(.M(M)) u_core (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (core_start),
    .i_a_mag (a_mag),
    .i_b_mag (b_mag),
    .o_last  (core_last),
    .o_prod  (core_prod),
    .o_quot  (core_quot)
  );

  assign o_ready  = (state_q == IDLE) && !i_rst;
  assign o_valid  = (state_q == DONE);
  assign o_result = result_q;
  assign o_status = status_q;

endmodule

// File: tb/tb_exe_unit_seq.sv
// Scoreboard bench for exe_unit_seq (M=8, N=3). The driver pushes the expected
// result, status and latency of each accepted request; a monitor pops and
// compares on every rising o_valid.
module tb_exe_unit_seq;

  localparam int M = 8;
  localparam int N = 3;

  localparam logic [1:0] S_OK   = 2'b00;
  localparam logic [1:0] S_OVF  = 2'b01;
  localparam logic [1:0] S_ZERO = 2'b10;
  localparam logic [1:0] S_ERR  = 2'b11;

  localparam logic [N-1:0] O_ADD = 3'd0;
  localparam logic [N-1:0] O_SUB = 3'd1;
  localparam logic [N-1:0] O_MAX = 3'd2;
  localparam logic [N-1:0] O_NEG = 3'd3;
  localparam logic [N-1:0] O_MUL = 3'd4;
  localparam logic [N-1:0] O_DIV = 3'd5;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b1;
  logic [N-1:0] i_oper = '0;
  logic [M-1:0] i_argA = '0;
  logic [M-1:0] i_argB = '0;
  logic         o_ready, o_valid;
  logic [M-1:0] o_result;
  logic [1:0]   o_status;

  typedef struct {
    logic [M-1:0] result;
    logic [1:0]   status;
    int           lat;
    int           acc_cyc;
    int           tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tag_cnt = 0;
  logic prev_valid = 1'b0;

  exe_unit_seq #(.M(M), .N(N)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_oper   (i_oper),
    .i_argA   (i_argA),
    .i_argB   (i_argB),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_status (o_status)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (txn %0d): got %0h, expected %0h", name, tag, act, exp);
    end
  endtask

  // Issue one request once the unit is ready and record what must come back.
  // Operands are scrambled right after the accept edge to show they are latched.
  task automatic applyStimulus(input logic [N-1:0] op, input logic [M-1:0] a, input logic [M-1:0] b,
                               input logic [M-1:0] er, input logic [1:0] es, input int lat);
    int   waited = 0;
    exp_t e;
    @(negedge i_clk);
    while (!o_ready && waited < 100) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: o_ready=%0b after %0d cycles, expected 1", o_ready, waited);
      return;
    end
    i_valid = 1'b1;
    i_oper  = op;
    i_argA  = a;
    i_argB  = b;
    @(posedge i_clk);
    #1;
    e.result  = er;
    e.status  = es;
    e.lat     = lat;
    e.acc_cyc = cyc;
    e.tag     = tag_cnt;
    tag_cnt++;
    sb.push_back(e);
    i_valid = 1'b0;
    i_oper  = N'($urandom_range(0, 7));
    i_argA  = M'($urandom);
    i_argB  = M'($urandom);
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge i_clk);
  endtask

  // Monitor: every new o_valid must match the oldest outstanding request.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: o_valid=1 o_result=%0h, expected no result", o_result);
      end else begin
        e = sb.pop_front();
        checkOutput("result", e.tag, 32'(o_result), 32'(e.result));
        checkOutput("status", e.tag, 32'(o_status), 32'(e.status));
        checkOutput("latency", e.tag, cyc - e.acc_cyc + 1, e.lat);
      end
    end
    prev_valid = o_valid;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values while reset is held and just after release.
    repeat (2) @(negedge i_clk);
    checkOutput("rst_ready", -1, 32'(o_ready), 0);
    checkOutput("rst_valid", -1, 32'(o_valid), 0);
    checkOutput("rst_result", -1, 32'(o_result), 0);
    checkOutput("rst_status", -1, 32'(o_status), 0);
    i_rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", -1, 32'(o_ready), 1);

    // Single-cycle operations, latency 1.
    applyStimulus(O_ADD, 8'h7F, 8'h01, 8'h80, S_OVF,  1);
    applyStimulus(O_ADD, 8'h05, 8'hFB, 8'h00, S_ZERO, 1);
    applyStimulus(O_SUB, 8'h80, 8'h01, 8'h7F, S_OVF,  1);
    applyStimulus(O_SUB, 8'h03, 8'h05, 8'hFE, S_OK,   1);
    applyStimulus(O_MAX, 8'hFD, 8'h02, 8'h02, S_OK,   1);
    applyStimulus(O_NEG, 8'h80, 8'h00, 8'h80, S_OVF,  1);
    applyStimulus(O_NEG, 8'h05, 8'h33, 8'hFB, S_OK,   1);
    applyStimulus(3'd6,  8'h12, 8'h34, 8'h00, S_ERR,  1);
    applyStimulus(3'd7,  8'h01, 8'h01, 8'h00, S_ERR,  1);

    // Multi-cycle operations, latency M+1.
    applyStimulus(O_MUL, 8'h03, 8'hFE, 8'hFA, S_OK,   9);
    applyStimulus(O_MUL, 8'h10, 8'h08, 8'h80, S_OVF,  9);
    applyStimulus(O_MUL, 8'h80, 8'h80, 8'h00, S_OVF,  9);
    applyStimulus(O_MUL, 8'h00, 8'h05, 8'h00, S_ZERO, 9);
    applyStimulus(O_DIV, 8'h07, 8'h00, 8'h00, S_ERR,  9);
    applyStimulus(O_DIV, 8'h80, 8'hFF, 8'h80, S_OVF,  9);
    applyStimulus(O_DIV, 8'hF9, 8'h02, 8'hFD, S_OK,   9);
    applyStimulus(O_DIV, 8'h7F, 8'h80, 8'h00, S_ZERO, 9);
    applyStimulus(O_DIV, 8'h80, 8'h02, 8'hC0, S_OK,   9);
    drain();

    // Backpressure: result must hold for three stalled cycles while stray
    // requests are ignored; a request overlapping the result handshake is taken
    // only in the following IDLE cycle.
    i_ready = 1'b0;
    applyStimulus(O_ADD, 8'h10, 8'h20, 8'h30, S_OK, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      checkOutput("stall_valid", k, 32'(o_valid), 1);
      checkOutput("stall_result", k, 32'(o_result), 32'h30);
      checkOutput("stall_status", k, 32'(o_status), 32'(S_OK));
      checkOutput("stall_ready", k, 32'(o_ready), 0);
      i_valid = (k % 2 == 0);
      i_oper  = O_ADD;
      i_argA  = 8'h01;
      i_argB  = 8'h01;
    end
    @(negedge i_clk);
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_oper  = O_ADD;
    i_argA  = 8'h02;
    i_argB  = 8'h03;
    @(posedge i_clk);
    #1;
    checkOutput("handshake_valid_drop", -1, 32'(o_valid), 0);
    applyStimulus(O_ADD, 8'h02, 8'h03, 8'h05, S_OK, 1);
    drain();

    // Reset in the middle of a multiply: everything clears at once and the
    // aborted operation never produces a result.
    @(negedge i_clk);
    i_valid = 1'b1;
    i_oper  = O_MUL;
    i_argA  = 8'h05;
    i_argB  = 8'h07;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #3;
    i_rst = 1'b1;
    #1;
    checkOutput("midrst_valid", -1, 32'(o_valid), 0);
    checkOutput("midrst_result", -1, 32'(o_result), 0);
    checkOutput("midrst_status", -1, 32'(o_status), 0);
    checkOutput("midrst_ready", -1, 32'(o_ready), 0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    checkOutput("ready_after_midrst", -1, 32'(o_ready), 1);
    repeat (12) @(negedge i_clk);
    applyStimulus(O_ADD, 8'h01, 8'h01, 8'h02, S_OK, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
